// File: rtl/float_discriminant_distributor_if.sv
// Argument/result bus between an upstream triple source, the discriminant
// distributor and the downstream result consumer.
interface float_discriminant_distributor_if #(
  parameter int FLEN = 64
);
  logic            arg_vld;
  logic [FLEN-1:0] a;
  logic [FLEN-1:0] b;
  logic [FLEN-1:0] c;
  logic            res_vld;
  logic [FLEN-1:0] res;
  logic            res_negative;
  logic            err;
  logic            busy;

  modport master (
    output arg_vld, a, b, c,
    input  res_vld, res, res_negative, err, busy
  );

  modport slave (
    input  arg_vld, a, b, c,
    output res_vld, res, res_negative, err, busy
  );
endinterface

// File: rtl/float_discriminant_distributor.sv
// FP64 discriminant b*b - 4*a*c: a variable-latency unit plus a round-robin
// front-end that time-shares N_UNITS of them and releases results in order.

module float_discriminant (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [63:0] c_i,
  output logic        res_vld_o,
  output logic [63:0] res_o,
  output logic        res_negative_o,
  output logic        err_o
);
  // Exact products, truncating normalisation one bit per cycle (latency
  // grows with cancellation); subnormals flush to zero, Inf/NaN in -> err.
  typedef enum logic {U_IDLE, U_NORM} unit_state_e;

  unit_state_e        state_q, state_d;
  logic [107:0]       mag_q, mag_d;
  logic [12:0]        ex_q, ex_d;
  logic [6:0]         sh_q, sh_d;
  logic               sign_q, sign_d, bad_q, bad_d;
  logic               res_vld_q, res_vld_d, err_q, err_d;
  logic [63:0]        res_q, res_d;

  logic [10:0]        ea, eb, ec;
  logic [52:0]        ma, mb, mc;
  logic [105:0]       p1, p2;
  logic [12:0]        x1, x2, ex_in;
  logic [107:0]       al1, al2, sum;
  logic               sgn, special;
  logic signed [14:0] exp_s;

  always_comb begin
    ea      = a_i[62:52];
    eb      = b_i[62:52];
    ec      = c_i[62:52];
    ma      = (ea == '0) ? '0 : {1'b1, a_i[51:0]};
    mb      = (eb == '0) ? '0 : {1'b1, b_i[51:0]};
    mc      = (ec == '0) ? '0 : {1'b1, c_i[51:0]};
    special = (&ea) | (&eb) | (&ec);
    p1      = 106'(mb) * 106'(mb);
    p2      = 106'(ma) * 106'(mc);
    // A zero product gets the smallest exponent so it never shifts the other away.
    x1      = (mb == '0) ? '0 : {1'b0, eb, 1'b0};
    x2      = (ma == '0 || mc == '0) ? '0 : 13'(ea) + 13'(ec) + 13'd2;
    if (x1 >= x2) begin
      al1   = {2'b00, p1};
      al2   = {2'b00, p2} >> (x1 - x2);
      ex_in = x1;
    end else begin
      al1   = {2'b00, p1} >> (x2 - x1);
      al2   = {2'b00, p2};
      ex_in = x2;
    end
    if (a_i[63] ^ c_i[63]) begin
      sum = al1 + al2;
      sgn = 1'b0;
    end else if (al1 >= al2) begin
      sum = al1 - al2;
      sgn = 1'b0;
    end else begin
      sum = al2 - al1;
      sgn = 1'b1;
    end
  end

  assign exp_s = $signed({2'b00, ex_q}) - $signed({8'b0, sh_q}) - 15'sd1020;

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    ex_d      = ex_q;
    sh_d      = sh_q;
    sign_d    = sign_q;
    bad_d     = bad_q;
    res_vld_d = 1'b0;
    res_d     = res_q;
    err_d     = err_q;
    case (state_q)
      U_IDLE: if (arg_vld_i) begin
        mag_d   = sum;
        ex_d    = ex_in;
        sh_d    = '0;
        sign_d  = sgn;
        bad_d   = special;
        state_d = U_NORM;
      end
      U_NORM: begin
        if (bad_q) begin
          res_d     = 64'h7FF8_0000_0000_0000;
          err_d     = 1'b1;
          res_vld_d = 1'b1;
          state_d   = U_IDLE;
        end else if (mag_q == '0 || mag_q[107]) begin
          res_vld_d = 1'b1;
          state_d   = U_IDLE;
          err_d     = 1'b0;
          if (mag_q == '0 || exp_s <= 15'sd0) begin
            res_d = {sign_q & (|mag_q), 63'd0};
          end else if (exp_s >= 15'sd2047) begin
            res_d = {sign_q, 11'h7FF, 52'd0};
            err_d = 1'b1;
          end else begin
            res_d = {sign_q, exp_s[10:0], mag_q[106:55]};
          end
        end else begin
          mag_d = mag_q << 1;
          sh_d  = sh_q + 7'd1;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= U_IDLE;
      mag_q     <= '0;
      ex_q      <= '0;
      sh_q      <= '0;
      sign_q    <= 1'b0;
      bad_q     <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      ex_q      <= ex_d;
      sh_q      <= sh_d;
      sign_q    <= sign_d;
      bad_q     <= bad_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  assign res_vld_o      = res_vld_q;
  assign res_o          = res_q;
  assign res_negative_o = res_q[63];
  assign err_o          = err_q;
endmodule

module float_discriminant_distributor #(
  parameter int N_UNITS = 4
) (
  input logic                              clk,
  input logic                              rst,
  float_discriminant_distributor_if.slave  bus_if
);
  localparam int FLEN  = 64;
  localparam int PTR_W = $clog2(N_UNITS);

  typedef enum logic [1:0] {SLOT_FREE, SLOT_RUN, SLOT_DONE} slot_e;

  slot_e             slot_q [N_UNITS];
  slot_e             slot_d [N_UNITS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FLEN-1:0]   hold_res_q [N_UNITS];
  logic              hold_neg_q [N_UNITS];
  logic              hold_err_q [N_UNITS];
  logic              res_vld_q, res_neg_q, res_err_q;
  logic [FLEN-1:0]   res_q;

  logic [N_UNITS-1:0] u_vld, u_res_vld, u_neg, u_err;
  logic [FLEN-1:0]    u_res [N_UNITS];
  logic               busy, dispatch, collect;

  // busy looks only at registered slot state, so it never depends on arg_vld.
  assign busy     = (slot_q[wr_ptr_q] != SLOT_FREE);
  assign dispatch = bus_if.arg_vld && !busy;
  assign collect  = (slot_q[rd_ptr_q] == SLOT_DONE);

  for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
    assign u_vld[i] = dispatch && (wr_ptr_q == PTR_W'(i));
    float_discriminant u_disc (
      .clk            (clk),
      .rst            (rst),
      .arg_vld_i      (u_vld[i]),
      .a_i            (bus_if.a),
      .b_i            (bus_if.b),
      .c_i            (bus_if.c),
      .res_vld_o      (u_res_vld[i]),
      .res_o          (u_res[i]),
      .res_negative_o (u_neg[i]),
      .err_o          (u_err[i])
    );
  end

  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_FREE: if (u_vld[i]) slot_d[i] = SLOT_RUN;
        SLOT_RUN:  if (u_res_vld[i]) slot_d[i] = SLOT_DONE;
        SLOT_DONE: if (collect && rd_ptr_q == PTR_W'(i)) slot_d[i] = SLOT_FREE;
        default:   slot_d[i] = SLOT_FREE;
      endcase
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(dispatch);
    rd_ptr_d = rd_ptr_q + PTR_W'(collect);
  end

  // NOTE: the hold registers are reset along with the slot state; they are a
  // handful of flops, and a clean zero keeps post-reset outputs deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_UNITS; i++) begin
        slot_q[i]     <= SLOT_FREE;
        hold_res_q[i] <= '0;
        hold_neg_q[i] <= 1'b0;
        hold_err_q[i] <= 1'b0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      res_neg_q <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        slot_q[i] <= slot_d[i];
        if (slot_q[i] == SLOT_RUN && u_res_vld[i]) begin
          hold_res_q[i] <= u_res[i];
          hold_neg_q[i] <= u_neg[i];
          hold_err_q[i] <= u_err[i];
        end
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      res_vld_q <= collect;
      if (collect) begin
        res_q     <= hold_res_q[rd_ptr_q];
        res_neg_q <= hold_neg_q[rd_ptr_q];
        res_err_q <= hold_err_q[rd_ptr_q];
      end
    end
  end

  assign bus_if.res_vld      = res_vld_q;
  assign bus_if.res          = res_q;
  assign bus_if.res_negative = res_neg_q;
  assign bus_if.err          = res_err_q;
  assign bus_if.busy         = busy;
endmodule

// File: tb/tb_float_discriminant_distributor.sv
// Directed + random bench for the distributor; expected results come from
// IEEE double arithmetic on integer-valued coefficients, released in accept order.
module tb_float_discriminant_distributor;
  localparam int N_UNITS = 4;
  localparam logic [63:0] P_INF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] Q_NAN = 64'h7FF8_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_discriminant_distributor_if #(.FLEN(64)) bus ();
  float_discriminant_distributor #(.N_UNITS(N_UNITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  typedef struct packed {
    logic        err;
    logic [63:0] res;
  } exp_t;

  exp_t        exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;
  logic [63:0] hold_res = '0;
  logic        hold_err = 1'b0;
  logic        hold_known = 1'b1;

  function automatic logic [63:0] fp(input int v);
    return $realtobits(real'(v));
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c);
    exp_t e;
    if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF || c[62:52] == 11'h7FF) begin
      e.err = 1'b1;
      e.res = '0;
    end else begin
      e.err = 1'b0;
      e.res = $realtobits($bitstoreal(b) * $bitstoreal(b)
                          - 4.0 * $bitstoreal(a) * $bitstoreal(c));
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result monitor: one sample per cycle, 1 time unit after the clock edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      hold_res   = '0;
      hold_err   = 1'b0;
      hold_known = 1'b1;
    end else if (bus.res_vld) begin
      exp_t e;
      pulses++;
      check("pending_at_pulse", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_err", 64'(bus.err), 64'(e.err));
        if (!e.err) begin
          check("res_value", bus.res, e.res);
          check("res_negative", 64'(bus.res_negative), 64'(e.res[63]));
        end
        hold_res   = e.res;
        hold_err   = e.err;
        hold_known = !e.err;
      end
    end else begin
      check("hold_err", 64'(bus.err), 64'(hold_err));
      if (hold_known) begin
        check("hold_res", bus.res, hold_res);
        check("hold_negative", 64'(bus.res_negative), 64'(hold_res[63]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      check("busy_idle", 64'(bus.busy), 64'(exp_q.size() >= N_UNITS));
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    check("busy", 64'(bus.busy), 64'(exp_q.size() >= N_UNITS));
    bus.arg_vld = 1'b1;
    bus.a       = a;
    bus.b       = b;
    bus.c       = c;
    if (exp_q.size() < N_UNITS) exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #2;
    bus.arg_vld = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
    idle(2);
    check("busy_after_drain", 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [63:0] rand_coef(input int range);
    int sel = int'($urandom_range(0, 31));
    if (sel == 0) return P_INF;
    if (sel == 1) return Q_NAN;
    return fp(int'($urandom_range(0, 2 * range)) - range);
  endfunction

  initial begin
    int p0;
    bus.arg_vld = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    #3;
    check("rst_res_vld", 64'(bus.res_vld), 64'd0);
    check("rst_res", bus.res, 64'd0);
    check("rst_negative", 64'(bus.res_negative), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);

    drive(fp(1), fp(4), fp(2));
    drain();
    check("t1_res", bus.res, 64'h4020_0000_0000_0000);
    check("t1_err", 64'(bus.err), 64'd0);

    drive(fp(1), fp(1), fp(1));
    drain();
    check("t2_res", bus.res, 64'hC008_0000_0000_0000);
    check("t2_negative", 64'(bus.res_negative), 64'd1);
    drive(fp(1), fp(2), fp(1));
    drain();
    check("t3_res", bus.res, 64'd0);
    check("t3_negative", 64'(bus.res_negative), 64'd0);

    // N_UNITS+1 back-to-back: the last one meets busy and is dropped.
    p0 = pulses;
    for (int k = 0; k <= N_UNITS; k++) drive(fp(k + 1), fp(5 * (k + 1)), fp(-k));
    drain();
    check("burst_pulses", 64'(pulses - p0), 64'(N_UNITS));

    drive(fp(2), fp(3), fp(1));
    drive(fp(1), P_INF, fp(2));
    drive(fp(3), fp(1), fp(-2));
    drain();
    check("inf_tail_err", 64'(bus.err), 64'd0);

    repeat (400) begin
      if ($urandom_range(0, 9) < 7 && exp_q.size() < N_UNITS)
        drive(rand_coef(1000), rand_coef(2000), rand_coef(1000));
      else
        idle(1);
    end
    drain();

    // Reset with three long-cancellation triples in flight.
    for (int k = 0; k < 3; k++) drive(fp(250500), fp(1001), fp(1));
    idle(2);
    rst = 1'b1;
    #1;
    check("mid_rst_res_vld", 64'(bus.res_vld), 64'd0);
    check("mid_rst_res", bus.res, 64'd0);
    check("mid_rst_negative", 64'(bus.res_negative), 64'd0);
    check("mid_rst_err", 64'(bus.err), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    p0 = pulses;
    idle(50);
    check("post_rst_quiet", 64'(pulses - p0), 64'd0);

    // Unit 0 gets a slow triple, unit 1 a fast one; release stays 0 then 1.
    p0 = pulses;
    drive(fp(250500), fp(1001), fp(1));
    drive(fp(1), fp(4), fp(2));
    drain();
    check("order_pulses", 64'(pulses - p0), 64'd2);
    check("order_last_res", bus.res, 64'h4020_0000_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
